spike_rate_decoder: RTL and testbench
=====================================

Name: spike_rate_decoder

Overview:
- Receiving end of the neuron spike interface: consumes the 1-bit spike stream from a neuron and turns it back into numbers.
- Counts spikes over a programmable window of clock cycles and presents the count as a rate word on a valid/ready output.
- Also measures the inter-spike interval (ISI) continuously.
- Sits downstream of a neuron instance, feeding readout or learning logic.

Parameters:
CNT_W, 8, width of the spike count / rate output (saturating)
WIN_W, 8, width of the window length input
ISI_W, 8, width of the ISI counter and output (saturating)

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
spike  input  1  spike from neuron; 1 cycle high = 1 spike; consecutive high cycles = consecutive spikes
enable  input  1  run windows while high
window_len  input  WIN_W  window length in cycles; sampled at window start
out_ready  input  1  consumer ready
rate  output  CNT_W  spike count of the last completed window
rate_valid  output  1  rate holds an unconsumed result
rate_sat  output  1  count saturated in the window that produced rate
missed  output  1  sticky: a spike arrived while in HOLD; cleared only by reset
isi  output  ISI_W  cycles between the last two spikes (saturating)
isi_valid  output  1  1-cycle pulse when isi updates
busy  output  1  high in COUNT state

Behaviour:
- Reset (async, immediate): state=IDLE. rate, rate_valid, rate_sat, missed, isi, isi_valid, busy all 0. Internal counters 0; seen-spike flag cleared. Reset mid-window discards the window with no output.
- FSM states:
  - IDLE: if enable=1 and window_len!=0, load win_cnt=window_len and spk_cnt=0, then go to COUNT. window_len=0 keeps the block in IDLE.
  - COUNT (busy=1): each cycle, if spike then spk_cnt increments, saturating at 2^CNT_W-1; reaching saturation sets an internal sat flag. win_cnt decrements each cycle.
    - On the cycle win_cnt==1, that cycle's spike is included. Then rate<=final count, rate_sat<=sat, rate_valid<=1, go to HOLD.
    - A window of N cycles covers exactly N spike samples; rate_valid rises on the clock edge ending the last sample.
    - enable=0 in COUNT: abort next edge to IDLE, no output, rate and rate_valid unchanged.
  - HOLD: rate_valid=1, rate and rate_sat stable until handshake (rate_valid & out_ready on a rising edge). The handshake edge clears rate_valid.
    - If enable=1 and window_len!=0 at the handshake edge, reload and enter COUNT directly (one-cycle gap, no IDLE visit). Otherwise go to IDLE.
    - A spike in HOLD sets missed. Spikes in IDLE are ignored and do not set missed.
  - enable=0 in HOLD does not drop the pending result.
- ISI path (independent of the FSM and enable):
  - isi_cnt increments every cycle, saturating at 2^ISI_W-1.
  - On a spike: if the seen flag is set, isi<=isi_cnt and isi_valid pulses. Then isi_cnt<=1 and seen<=1.
  - The first spike after reset produces no isi_valid.
  - Spikes at cycles t0 and t1 give isi=t1-t0. Back-to-back spikes give isi=1. Gaps of 2^ISI_W-1 or more report 2^ISI_W-1.
- Width rules: counters are unsigned; saturation is never wrap-around. window_len is captured only at window start; changes mid-window are ignored.

Decomposition:
- Shared neuron package:
  - FSM state encoding (IDLE, COUNT, HOLD)
  - default widths CNT_W, WIN_W, ISI_W
  - a saturating-increment function reused by both counters
- One natural sub-module: spike_isi_meter (ISI counter, seen flag, isi/isi_valid). It has no FSM dependency.
- Windowed counter, FSM and output register stay in the top.

Test Plan:
- Reset, then enable=1, window_len=10, spike high on cycles 2,5,9 of the window, out_ready=1 -> rate=3, rate_valid high 1 cycle after the 10th sample, rate_sat=0, next window starts.
- window_len=4, spike held high all window -> rate=4. Same with CNT_W=2, window_len=8 -> rate=3, rate_sat=1.
- Window completes with out_ready=0 for 5 cycles and spikes during HOLD -> rate stable, rate_valid held, missed=1. Raise out_ready -> rate_valid drops next edge, new window begins.
- Spikes at absolute cycles 3, 7, 8 -> isi_valid pulses at 7 (isi=4) and 8 (isi=1), none at 3. ISI_W=4 with a 40-cycle gap -> isi=15.
- enable dropped mid-window (window_len=20, after 6 cycles) -> IDLE, no rate_valid. window_len=0 with enable=1 -> stays IDLE, busy=0.
- Assert reset asynchronously mid-COUNT and mid-HOLD -> all outputs 0 immediately, no handshake. The first spike after release gives no isi_valid.

Source files
------------

// File: rtl/spike_rate_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spike_rate_decoder_pkg
// Description : Shared definitions for the spike rate decoder. Holds the FSM
//               state encoding, default widths and a saturating-increment
//               helper used by both the spike counter and the ISI counter.
// Revision    : 1.0 - initial release
// ============================================================================
package spike_rate_decoder_pkg;

  localparam int DEF_CNT_W = 8;
  localparam int DEF_WIN_W = 8;
  localparam int DEF_ISI_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Increment that sticks at max_val instead of wrapping. Operands are
  // zero-extended to 32 bits by the caller and truncated back afterwards.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic [31:0] max_val);
    if (val >= max_val) begin
      return max_val;
    end
    return val + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spike_rate_decoder_isi_meter.sv
`default_nettype none
// ============================================================================
// Module      : spike_isi_meter
// Description : Inter-spike interval meter. A free-running saturating counter
//               is sampled into isi on every spike after the first one, then
//               restarted at 1 so that spikes at t0 and t1 report t1-t0.
// Ports       : clk       - clock, rising edge
//               reset     - asynchronous active-high reset
//               spike     - 1-bit spike input
//               isi       - cycles between the last two spikes (saturating)
//               isi_valid - one-cycle pulse when isi is updated
// Revision    : 1.0 - initial release
// ============================================================================
module spike_isi_meter
  import spike_rate_decoder_pkg::*;
#(
  parameter int ISI_W = DEF_ISI_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             spike,
  output logic [ISI_W-1:0] isi,
  output logic             isi_valid
);

  localparam logic [ISI_W-1:0] c_isi_max = '1;

  logic [ISI_W-1:0] r_isi_cnt;
  logic             r_seen;
  logic [ISI_W-1:0] r_isi;
  logic             r_isi_valid;
  logic [ISI_W-1:0] w_isi_cnt_inc;

  assign w_isi_cnt_inc = ISI_W'(sat_inc(32'(r_isi_cnt), 32'(c_isi_max)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_isi_cnt   <= '0;
      r_seen      <= 1'b0;
      r_isi       <= '0;
      r_isi_valid <= 1'b0;
    end else if (spike) begin
      // The very first spike only arms the meter; there is no earlier spike
      // to measure against.
      if (r_seen) begin
        r_isi       <= r_isi_cnt;
        r_isi_valid <= 1'b1;
      end else begin
        r_isi_valid <= 1'b0;
      end
      r_isi_cnt <= ISI_W'(1);
      r_seen    <= 1'b1;
    end else begin
      r_isi_cnt   <= w_isi_cnt_inc;
      r_isi_valid <= 1'b0;
    end
  end

  assign isi       = r_isi;
  assign isi_valid = r_isi_valid;

endmodule
`default_nettype wire

// File: rtl/spike_rate_decoder.sv
`default_nettype none
// ============================================================================
// Module      : spike_rate_decoder
// Description : Converts a 1-bit neuron spike stream back into numbers. Counts
//               spikes over a programmable window and presents the count on a
//               valid/ready output; also measures inter-spike interval.
// Ports       : clk        - clock, rising edge
//               reset      - asynchronous active-high reset
//               spike      - spike input, one high cycle per spike
//               enable     - run windows while high
//               window_len - window length in cycles, sampled at window start
//               out_ready  - consumer ready
//               rate       - spike count of the last completed window
//               rate_valid - rate holds an unconsumed result
//               rate_sat   - count saturated in the window that produced rate
//               missed     - sticky, a spike arrived while holding a result
//               isi        - cycles between the last two spikes
//               isi_valid  - one-cycle pulse when isi updates
//               busy       - high while counting a window
// Revision    : 1.0 - initial release
// ============================================================================
module spike_rate_decoder
  import spike_rate_decoder_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int WIN_W = DEF_WIN_W,
  parameter int ISI_W = DEF_ISI_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             spike,
  input  logic             enable,
  input  logic [WIN_W-1:0] window_len,
  input  logic             out_ready,
  output logic [CNT_W-1:0] rate,
  output logic             rate_valid,
  output logic             rate_sat,
  output logic             missed,
  output logic [ISI_W-1:0] isi,
  output logic             isi_valid,
  output logic             busy
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIN_W-1:0] r_win_cnt;
  logic [WIN_W-1:0] w_win_cnt_nxt;
  logic [CNT_W-1:0] r_spk_cnt;
  logic [CNT_W-1:0] w_spk_cnt_nxt;
  logic             r_sat;
  logic             w_sat_nxt;
  logic [CNT_W-1:0] r_rate;
  logic [CNT_W-1:0] w_rate_nxt;
  logic             r_rate_valid;
  logic             w_rate_valid_nxt;
  logic             r_rate_sat;
  logic             w_rate_sat_nxt;
  logic             r_missed;
  logic             w_missed_nxt;

  logic             w_start;
  logic [CNT_W-1:0] w_spk_cnt_inc;
  logic             w_sat_inc;

  // A window may only start with a non-zero length.
  assign w_start = enable && (window_len != '0);

  // Count including this cycle's spike sample, and its saturation status.
  assign w_spk_cnt_inc = spike ? CNT_W'(sat_inc(32'(r_spk_cnt), 32'(c_cnt_max)))
                               : r_spk_cnt;
  assign w_sat_inc     = r_sat || (w_spk_cnt_inc == c_cnt_max);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath next values
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt      = r_state;
    w_win_cnt_nxt    = r_win_cnt;
    w_spk_cnt_nxt    = r_spk_cnt;
    w_sat_nxt        = r_sat;
    w_rate_nxt       = r_rate;
    w_rate_valid_nxt = r_rate_valid;
    w_rate_sat_nxt   = r_rate_sat;
    w_missed_nxt     = r_missed || ((r_state == ST_HOLD) && spike);

    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_win_cnt_nxt = window_len;
          w_spk_cnt_nxt = '0;
          w_sat_nxt     = 1'b0;
          w_state_nxt   = ST_COUNT;
        end
      end

      ST_COUNT: begin
        if (!enable) begin
          // Abort discards the partial window; previous result is untouched.
          w_state_nxt = ST_IDLE;
        end else if (r_win_cnt == WIN_W'(1)) begin
          // Last sample of the window is folded straight into the result.
          w_rate_nxt       = w_spk_cnt_inc;
          w_rate_sat_nxt   = w_sat_inc;
          w_rate_valid_nxt = 1'b1;
          w_state_nxt      = ST_HOLD;
        end else begin
          w_win_cnt_nxt = r_win_cnt - WIN_W'(1);
          w_spk_cnt_nxt = w_spk_cnt_inc;
          w_sat_nxt     = w_sat_inc;
        end
      end

      ST_HOLD: begin
        if (out_ready) begin
          w_rate_valid_nxt = 1'b0;
          if (w_start) begin
            // Back-to-back windows skip IDLE.
            w_win_cnt_nxt = window_len;
            w_spk_cnt_nxt = '0;
            w_sat_nxt     = 1'b0;
            w_state_nxt   = ST_COUNT;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_win_cnt    <= '0;
      r_spk_cnt    <= '0;
      r_sat        <= 1'b0;
      r_rate       <= '0;
      r_rate_valid <= 1'b0;
      r_rate_sat   <= 1'b0;
      r_missed     <= 1'b0;
    end else begin
      r_win_cnt    <= w_win_cnt_nxt;
      r_spk_cnt    <= w_spk_cnt_nxt;
      r_sat        <= w_sat_nxt;
      r_rate       <= w_rate_nxt;
      r_rate_valid <= w_rate_valid_nxt;
      r_rate_sat   <= w_rate_sat_nxt;
      r_missed     <= w_missed_nxt;
    end
  end

  assign rate       = r_rate;
  assign rate_valid = r_rate_valid;
  assign rate_sat   = r_rate_sat;
  assign missed     = r_missed;
  assign busy       = (r_state == ST_COUNT);

  // --------------------------------------------------------------------------
  // Inter-spike interval meter, independent of the window FSM
  // --------------------------------------------------------------------------
  spike_isi_meter #(
    .ISI_W (ISI_W)
  ) u_isi_meter (
    .clk       (clk),
    .reset     (reset),
    .spike     (spike),
    .isi       (isi),
    .isi_valid (isi_valid)
  );

endmodule
`default_nettype wire

// File: tb/tb_spike_rate_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_spike_rate_decoder
// Description : Directed self-checking bench. Two instances share stimulus:
//               u_dut_a uses default widths, u_dut_b uses CNT_W=2, ISI_W=4
//               so that saturation of both counters is observable.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spike_rate_decoder;

  logic       clk;
  logic       reset;
  logic       spike;
  logic       enable;
  logic [7:0] window_len;
  logic       out_ready;

  logic [7:0] rate_a;
  logic       rate_valid_a;
  logic       rate_sat_a;
  logic       missed_a;
  logic [7:0] isi_a;
  logic       isi_valid_a;
  logic       busy_a;

  logic [1:0] rate_b;
  logic       rate_valid_b;
  logic       rate_sat_b;
  logic       missed_b;
  logic [3:0] isi_b;
  logic       isi_valid_b;
  logic       busy_b;

  int n_cmp;
  int n_err;

  spike_rate_decoder #(
    .CNT_W (8),
    .WIN_W (8),
    .ISI_W (8)
  ) u_dut_a (
    .clk        (clk),
    .reset      (reset),
    .spike      (spike),
    .enable     (enable),
    .window_len (window_len),
    .out_ready  (out_ready),
    .rate       (rate_a),
    .rate_valid (rate_valid_a),
    .rate_sat   (rate_sat_a),
    .missed     (missed_a),
    .isi        (isi_a),
    .isi_valid  (isi_valid_a),
    .busy       (busy_a)
  );

  spike_rate_decoder #(
    .CNT_W (2),
    .WIN_W (8),
    .ISI_W (4)
  ) u_dut_b (
    .clk        (clk),
    .reset      (reset),
    .spike      (spike),
    .enable     (enable),
    .window_len (window_len),
    .out_ready  (out_ready),
    .rate       (rate_b),
    .rate_valid (rate_valid_b),
    .rate_sat   (rate_sat_b),
    .missed     (missed_b),
    .isi        (isi_b),
    .isi_valid  (isi_valid_b),
    .busy       (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rate"},       32'(rate_a),       0);
    chk({tag, "_valid"},      32'(rate_valid_a), 0);
    chk({tag, "_sat_b"},      32'(rate_sat_b),   0);
    chk({tag, "_missed"},     32'(missed_a),     0);
    chk({tag, "_isi"},        32'(isi_a),        0);
    chk({tag, "_isi_valid"},  32'(isi_valid_a),  0);
    chk({tag, "_busy"},       32'(busy_a),       0);
    chk({tag, "_valid_b"},    32'(rate_valid_b), 0);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    spike      = 1'b0;
    enable     = 1'b0;
    window_len = 8'd0;
    out_ready  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Load a window from IDLE and drive pat[i] as sample i. Ends in HOLD with
  // out_ready low and spike low.
  task automatic run_window(input int len, input logic [31:0] pat);
    enable     = 1'b1;
    window_len = 8'(len);
    out_ready  = 1'b0;
    spike      = 1'b0;
    tick();
    for (int i = 0; i < len; i++) begin
      spike = pat[i];
      tick();
      if (i == len - 2) chk("no_early_valid", 32'(rate_valid_a), 0);
    end
    spike = 1'b0;
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    reset      = 1'b1;
    spike      = 1'b0;
    enable     = 1'b0;
    window_len = 8'd0;
    out_ready  = 1'b0;
    #1;
    chk_all_zero("por");

    // ---- 10-cycle window, spikes on samples 2, 5, 9 ----
    do_reset();
    run_window(10, 32'h0000_0112);
    chk("w10_rate",  32'(rate_a),       3);
    chk("w10_valid", 32'(rate_valid_a), 1);
    chk("w10_sat",   32'(rate_sat_a),   0);
    chk("w10_busy",  32'(busy_a),       0);
    chk("w10_isi",   32'(isi_a),        4);
    out_ready = 1'b1;
    tick();
    chk("w10_hs_valid", 32'(rate_valid_a), 0);
    chk("w10_hs_busy",  32'(busy_a),       1);
    chk("w10_hs_rate",  32'(rate_a),       3);
    enable    = 1'b0;
    out_ready = 1'b0;
    tick();

    // ---- 4-cycle window, spike held high; then hold with spikes ----
    do_reset();
    run_window(4, 32'h0000_000F);
    chk("w4_rate_a",   32'(rate_a),     4);
    chk("w4_sat_a",    32'(rate_sat_a), 0);
    chk("w4_rate_b",   32'(rate_b),     3);
    chk("w4_sat_b",    32'(rate_sat_b), 1);
    chk("w4_missed",   32'(missed_a),   0);
    chk("w4_isi",      32'(isi_a),      1);
    spike = 1'b1;
    repeat (5) tick();
    spike = 1'b0;
    chk("hold_rate",   32'(rate_a),       4);
    chk("hold_valid",  32'(rate_valid_a), 1);
    chk("hold_missed", 32'(missed_a),     1);
    chk("hold_rate_b", 32'(rate_b),       3);
    out_ready = 1'b1;
    tick();
    chk("hold_hs_valid",  32'(rate_valid_a), 0);
    chk("hold_hs_busy",   32'(busy_a),       1);
    chk("hold_hs_missed", 32'(missed_a),     1);
    enable    = 1'b0;
    out_ready = 1'b0;
    tick();

    // ---- 8-cycle window, all spikes ----
    do_reset();
    run_window(8, 32'h0000_00FF);
    chk("w8_rate_a", 32'(rate_a),     8);
    chk("w8_sat_a",  32'(rate_sat_a), 0);
    chk("w8_rate_b", 32'(rate_b),     3);
    chk("w8_sat_b",  32'(rate_sat_b), 1);

    // ---- ISI: spikes at 3, 7, 8 with windows disabled ----
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      spike = (c == 3) || (c == 7) || (c == 8);
      tick();
      if (c == 3) chk("isi_first_none", 32'(isi_valid_a), 0);
      if (c == 7) begin
        chk("isi_7_valid", 32'(isi_valid_a), 1);
        chk("isi_7_val",   32'(isi_a),       4);
      end
      if (c == 8) begin
        chk("isi_8_valid", 32'(isi_valid_a), 1);
        chk("isi_8_val",   32'(isi_a),       1);
      end
      if (c == 9) chk("isi_pulse_end", 32'(isi_valid_a), 0);
    end
    spike = 1'b0;
    chk("idle_no_missed", 32'(missed_a), 0);
    chk("idle_no_busy",   32'(busy_a),   0);
    spike = 1'b1;
    tick();
    spike = 1'b0;
    repeat (39) tick();
    spike = 1'b1;
    tick();
    spike = 1'b0;
    chk("gap40_isi_a", 32'(isi_a),       40);
    chk("gap40_isi_b", 32'(isi_b),       15);
    chk("gap40_valid", 32'(isi_valid_b), 1);

    // ---- abort mid-window, zero length, mid-window length change ----
    do_reset();
    enable     = 1'b1;
    window_len = 8'd20;
    tick();
    repeat (6) tick();
    chk("abort_busy_before", 32'(busy_a), 1);
    enable = 1'b0;
    tick();
    chk("abort_busy_after", 32'(busy_a), 0);
    repeat (25) tick();
    chk("abort_no_valid", 32'(rate_valid_a), 0);
    enable     = 1'b1;
    window_len = 8'd0;
    repeat (3) tick();
    chk("zero_len_busy",  32'(busy_a),       0);
    chk("zero_len_valid", 32'(rate_valid_a), 0);
    window_len = 8'd3;
    tick();
    window_len = 8'd10;
    repeat (2) tick();
    chk("len_capture_early", 32'(rate_valid_a), 0);
    tick();
    chk("len_capture_done", 32'(rate_valid_a), 1);
    enable = 1'b0;

    // ---- asynchronous reset mid-COUNT ----
    do_reset();
    enable     = 1'b1;
    window_len = 8'd10;
    spike      = 1'b1;
    tick();
    repeat (3) tick();
    #2;
    reset = 1'b1;
    #1;
    chk("arst_count_busy",  32'(busy_a),       0);
    chk("arst_count_valid", 32'(rate_valid_a), 0);
    enable = 1'b0;
    spike  = 1'b0;
    #1;
    reset = 1'b0;
    tick();

    // ---- asynchronous reset mid-HOLD ----
    run_window(4, 32'h0000_000F);
    spike = 1'b1;
    tick();
    spike = 1'b0;
    chk("arst_hold_missed_pre", 32'(missed_a), 1);
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("arst_hold");
    enable = 1'b0;
    #1;
    reset = 1'b0;
    tick();
    spike = 1'b1;
    tick();
    spike = 1'b0;
    chk("post_rst_first_spike", 32'(isi_valid_a), 0);
    chk("post_rst_no_valid",    32'(rate_valid_a), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
